// File: rtl/fir_memory_master.sv
// Memory-mapped FIR engine: fetches NUM_TAPS Q15 coefficients, then for each output
// sample streams the needed input words, accumulates, and writes the Q15-scaled result.
module fir_memory_master #(
  parameter int NUM_TAPS  = 3,
  parameter int ACC_WIDTH = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  sampleCount,
  input  logic [31:0] inputBase,
  input  logic [31:0] coeffBase,
  input  logic [31:0] outputBase,
  output logic        busy,
  output logic        done,
  output logic        memoryReadEnable,
  output logic        memoryWriteEnable,
  output logic [2:0]  func3,
  output logic [31:0] memoryAddress,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  typedef enum logic [2:0] {IDLE, LOAD_COEF, CALC, WRITE, DONE} state_t;

  localparam logic [2:0] LAST_TAP = 3'(NUM_TAPS - 1);
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;

  state_t                      state_r;
  logic [7:0]                  count_r;
  logic [7:0]                  n_r;
  logic [2:0]                  k_r;
  logic [2:0]                  k_inc_s;
  logic [31:0]                 input_base_r;
  logic [31:0]                 coeff_base_r;
  logic [31:0]                 output_base_r;
  logic signed [15:0]          coef_r [8];
  logic signed [ACC_WIDTH-1:0] acc_r;
  logic signed [ACC_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0] acc_next_s;

  // Word address base+4*idx; the offset is word aligned, so masking the sum drops base[1:0].
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [7:0] idx);
    word_addr = (base + {22'd0, idx, 2'b00}) & 32'hFFFF_FFFC;
  endfunction

  // Tap product and running sum; a tap without a read strobe contributes zero.
  always_comb begin
    k_inc_s = k_r + 3'd1;
    if (memoryReadEnable) begin
      prod_s = ACC_WIDTH'($signed(readData)) * ACC_WIDTH'(coef_r[k_r]);
    end else begin
      prod_s = {ACC_WIDTH{1'b0}};
    end
    if (k_r == 3'd0) begin
      acc_next_s = prod_s;
    end else begin
      acc_next_s = acc_r + prod_s;
    end
  end

  // Job sequencer; every output is registered with the state it belongs to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r           <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      memoryReadEnable  <= 1'b0;
      memoryWriteEnable <= 1'b0;
      func3             <= F3_WORD;
      memoryAddress     <= 32'd0;
      writeData         <= 32'd0;
      count_r           <= 8'd0;
      n_r               <= 8'd0;
      k_r               <= 3'd0;
      input_base_r      <= 32'd0;
      coeff_base_r      <= 32'd0;
      output_base_r     <= 32'd0;
      acc_r             <= {ACC_WIDTH{1'b0}};
      for (int i = 0; i < 8; i++) coef_r[i] <= 16'sd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            count_r       <= sampleCount;
            input_base_r  <= inputBase;
            coeff_base_r  <= coeffBase;
            output_base_r <= outputBase;
            n_r           <= 8'd0;
            k_r           <= 3'd0;
            if (sampleCount == 8'd0) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r          <= LOAD_COEF;
              busy             <= 1'b1;
              memoryReadEnable <= 1'b1;
              func3            <= F3_HALF;
              memoryAddress    <= word_addr(coeffBase, 8'd0);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD_COEF: begin
          coef_r[k_r] <= readData[15:0];
          if (k_r == LAST_TAP) begin
            state_r       <= CALC;
            k_r           <= 3'd0;
            n_r           <= 8'd0;
            func3         <= F3_WORD;
            memoryAddress <= word_addr(input_base_r, 8'd0);
          end else begin
            k_r           <= k_inc_s;
            memoryAddress <= word_addr(coeff_base_r, {5'd0, k_inc_s});
          end
        end
        CALC: begin
          acc_r <= acc_next_s;
          if (k_r == LAST_TAP) begin
            state_r           <= WRITE;
            memoryReadEnable  <= 1'b0;
            memoryWriteEnable <= 1'b1;
            memoryAddress     <= word_addr(output_base_r, n_r);
            writeData         <= acc_next_s[46:15];
          end else begin
            k_r <= k_inc_s;
            // Taps reaching before x[0] see zero history and skip the bus.
            if (n_r >= {5'd0, k_inc_s}) begin
              memoryReadEnable <= 1'b1;
              memoryAddress    <= word_addr(input_base_r, n_r - {5'd0, k_inc_s});
            end else begin
              memoryReadEnable <= 1'b0;
              memoryAddress    <= 32'd0;
            end
          end
        end
        WRITE: begin
          memoryWriteEnable <= 1'b0;
          writeData         <= 32'd0;
          if (n_r == count_r - 8'd1) begin
            state_r       <= DONE;
            busy          <= 1'b0;
            done          <= 1'b1;
            memoryAddress <= 32'd0;
          end else begin
            state_r          <= CALC;
            n_r              <= n_r + 8'd1;
            k_r              <= 3'd0;
            memoryReadEnable <= 1'b1;
            memoryAddress    <= word_addr(input_base_r, n_r + 8'd1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r           <= IDLE;
          busy              <= 1'b0;
          done              <= 1'b0;
          memoryReadEnable  <= 1'b0;
          memoryWriteEnable <= 1'b0;
          func3             <= F3_WORD;
          memoryAddress     <= 32'd0;
          writeData         <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/fir_memory_master.md
FIR_MEMORY_MASTER -- requirements
Module: fir_memory_master

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 3, number of Q15 filter coefficients (1..8).
REQ-002 SHALL have parameter ACC_WIDTH, default 48, signed accumulator width.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  job request, sampled only in IDLE.
REQ-006 SHALL have port sampleCount  input  8  number of input samples N (0..255).
REQ-007 SHALL have ports inputBase, coeffBase, outputBase  input  32 each  byte base addresses; bits [1:0] ignored (treated as 00).
REQ-008 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports memoryReadEnable, memoryWriteEnable  output  1 each  data-memory strobes.
REQ-011 SHALL have port func3  output  3  access size: 3'b001 for coefficient reads, 3'b010 for sample reads and result writes.
REQ-012 SHALL have ports memoryAddress, writeData  output  32 each; readData  input  32, valid combinationally in the same cycle as memoryReadEnable.

Function
REQ-013 SHALL compute y[n] = sum k=0..NUM_TAPS-1 of h[k]*x[n-k], n = 0..N-1, with x[m<0] = 0.
REQ-014 SHALL implement FSM states IDLE, LOAD_COEF, CALC, WRITE, DONE.
REQ-015 IDLE: start=1 with N>0 -> LOAD_COEF (latch bases, N); start=1 with N=0 -> DONE, no memory access; else stay.
REQ-016 LOAD_COEF: one read per cycle, k = 0..NUM_TAPS-1, address coeffBase+4k, func3=001; readData[15:0] stored as signed h[k]; after last tap -> CALC.
REQ-017 CALC: one cycle per tap k for the current n; if n-k >= 0, assert read at inputBase+4(n-k), func3=010, add signed readData*h[k] to the accumulator; else no read strobe, add 0.
REQ-018 CALC SHALL clear the accumulator at k=0 for each n; after k = NUM_TAPS-1 -> WRITE.
REQ-019 WRITE: one cycle, memoryWriteEnable=1, address outputBase+4n, func3=010, writeData = accumulator bits [46:15] (arithmetic shift right 15, truncate, no rounding, no saturation); n=N-1 -> DONE, else n+1 -> CALC.
REQ-020 Accumulator arithmetic SHALL be signed and wrap modulo 2^ACC_WIDTH.
REQ-021 DONE: done=1 for exactly one cycle, busy=0 in that cycle -> IDLE.
REQ-022 Latency for N>0: done asserted exactly NUM_TAPS + N*(NUM_TAPS+1) + 1 cycles after the start acceptance edge; for N=0, 1 cycle.
REQ-023 memoryReadEnable and memoryWriteEnable SHALL never be high together; both low in IDLE and DONE.
REQ-024 memoryAddress, writeData SHALL be 0 whenever both strobes are low; func3 SHALL be 3'b010 when idle.
REQ-025 start asserted while busy SHALL be ignored and not queued.
REQ-026 Address arithmetic SHALL wrap modulo 2^32.

Reset
REQ-027 reset low SHALL immediately force state IDLE, busy=0, done=0, both strobes 0, memoryAddress=0, writeData=0, func3=3'b010, accumulator, h[], counters to 0.
REQ-028 reset asserted mid-job SHALL abort with no further writes; the job is not resumed after release.
REQ-029 First start SHALL be accepted on the first rising edge after reset release.

Verification
REQ-030 Memory model x={4,8,12,16,20} at 0x00, h={8192,8192,8192} at 0x40, outputBase 0x80, N=5 -> writes 1,3,6,9,12 to 0x80..0x90; done at cycle 24.
REQ-031 Negative data: x={-32768,0}, h={16384,-16384,0}, N=2 -> y0=-16384, y1=16384.
REQ-032 N=0 with start -> done one cycle later, no strobes observed.
REQ-033 Reset driven low during third CALC of a N=5 job -> outputs zero same cycle, no WRITE, later job completes correctly.
REQ-034 start pulsed during busy and again after done -> exactly two jobs, two done pulses.
REQ-035 Assertion over all runs: never both strobes high; coefficient reads use func3=001, all others 010.
